// File: rtl/klotski_step_sequencer.sv
// Step sequencer for the Klotski solver: walks a programmable table of tile moves,
// launching the move engine once per step and carrying board and lock mask between steps.
module klotski_step_sequencer #(
  parameter int unsigned SIDE      = 4,
  parameter int unsigned CELL_W    = 4,
  parameter int unsigned MAX_STEPS = 32,
  parameter int unsigned TIMEOUT   = 4096,
  localparam int unsigned N        = SIDE * SIDE,
  localparam int unsigned IdxW     = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned SW       = $clog2(MAX_STEPS + 1),
  localparam int unsigned AddrW    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
  localparam int unsigned EntryW   = 1 + CELL_W + IdxW
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_prog_we,
  input  logic [AddrW-1:0]      i_prog_addr,
  input  logic [EntryW-1:0]     i_prog_data,
  input  logic [SW-1:0]         i_num_steps,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [N*CELL_W-1:0]   i_board,
  output logic                  o_eng_start,
  output logic [N*CELL_W-1:0]   o_eng_board,
  output logic [N-1:0]          o_eng_mask,
  output logic [CELL_W-1:0]     o_eng_number,
  output logic [IdxW-1:0]       o_eng_target,
  output logic                  o_eng_flag,
  input  logic                  i_eng_done,
  input  logic                  i_eng_fail,
  input  logic [N*CELL_W-1:0]   i_eng_board,
  input  logic [N-1:0]          i_eng_mask,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [1:0]            o_err_code,
  output logic [SW-1:0]         o_step,
  output logic [N*CELL_W-1:0]   o_board
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e                state_q, state_d;
  logic [N*CELL_W-1:0]   board_q, board_d;
  logic [N-1:0]          mask_q, mask_d;
  logic [SW-1:0]         step_q, step_d;
  logic [SW-1:0]         num_q, num_d;
  logic [EntryW-1:0]     entry_q, entry_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [EntryW-1:0]     table_q [MAX_STEPS];

  logic [SW-1:0]         step_inc;
  logic [SW-1:0]         num_clamp;

  assign step_inc  = step_q + SW'(1);
  assign num_clamp = (32'(i_num_steps) > MAX_STEPS) ? SW'(MAX_STEPS) : i_num_steps;

  // Table has no reset: contents are undefined until programmed.
  always_ff @(posedge i_clk) begin
    if (i_prog_we && (state_q == StIdle) && (32'(i_prog_addr) < MAX_STEPS)) begin
      table_q[i_prog_addr] <= i_prog_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    mask_d     = mask_q;
    step_d     = step_q;
    num_d      = num_q;
    entry_d    = entry_q;
    wd_d       = wd_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          board_d    = i_board;
          mask_d     = '0;
          step_d     = '0;
          num_d      = num_clamp;
          err_code_d = 2'd0;
          if (num_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StLaunch;
            entry_d = table_q[0];
          end
        end
      end
      StLaunch: begin
        wd_d    = '0;
        state_d = i_abort ? StIdle : StWait;
      end
      StWait: begin
        // Abort wins over a simultaneous done; nothing is committed.
        if (i_abort) begin
          state_d = StIdle;
        end else if (i_eng_done) begin
          if (i_eng_fail) begin
            error_d    = 1'b1;
            err_code_d = 2'd1;
            state_d    = StIdle;
          end else begin
            board_d = i_eng_board;
            mask_d  = i_eng_mask;
            step_d  = step_inc;
            if (step_inc < num_q) begin
              state_d = StLaunch;
              entry_d = table_q[step_inc[AddrW-1:0]];
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end else if ((TIMEOUT != 0) && (wd_q == WdLast)) begin
          error_d    = 1'b1;
          err_code_d = 2'd2;
          state_d    = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      board_q    <= '0;
      mask_q     <= '0;
      step_q     <= '0;
      num_q      <= '0;
      entry_q    <= '0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      mask_q     <= mask_d;
      step_q     <= step_d;
      num_q      <= num_d;
      entry_q    <= entry_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign o_eng_start  = (state_q == StLaunch);
  assign o_busy       = (state_q != StIdle);
  assign o_eng_board  = board_q;
  assign o_eng_mask   = mask_q;
  assign o_eng_flag   = entry_q[EntryW-1];
  assign o_eng_number = entry_q[IdxW +: CELL_W];
  assign o_eng_target = entry_q[IdxW-1:0];
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_err_code   = err_code_q;
  assign o_step       = step_q;
  assign o_board      = board_q;

endmodule

// File: tb/tb_klotski_step_sequencer.sv
// Scoreboard bench for klotski_step_sequencer: a behavioural engine answers launches, and a
// step-by-step model predicts every launch, done and error event with its cycle.
module tb_klotski_step_sequencer;

  localparam int SIDE = 4;
  localparam int CELL_W = 4;
  localparam int N = 16;
  localparam int IDXW = 4;
  localparam int EW = 9;
  localparam int MAXS = 8;
  localparam int TO = 16;
  localparam int SW = 4;
  localparam int AW = 3;
  localparam int BW = N * CELL_W;

  logic            clk = 1'b0;
  logic            i_rst_n = 1'b1;
  logic            i_prog_we = 1'b0;
  logic [AW-1:0]   i_prog_addr = '0;
  logic [EW-1:0]   i_prog_data = '0;
  logic [SW-1:0]   i_num_steps = '0;
  logic            i_start = 1'b0;
  logic            i_abort = 1'b0;
  logic [BW-1:0]   i_board = '0;
  logic            o_eng_start;
  logic [BW-1:0]   o_eng_board;
  logic [N-1:0]    o_eng_mask;
  logic [CELL_W-1:0] o_eng_number;
  logic [IDXW-1:0] o_eng_target;
  logic            o_eng_flag;
  logic            i_eng_done = 1'b0;
  logic            i_eng_fail = 1'b0;
  logic [BW-1:0]   i_eng_board = '0;
  logic [N-1:0]    i_eng_mask = '0;
  logic            o_busy, o_done, o_error;
  logic [1:0]      o_err_code;
  logic [SW-1:0]   o_step;
  logic [BW-1:0]   o_board;

  klotski_step_sequencer #(
    .SIDE(SIDE), .CELL_W(CELL_W), .MAX_STEPS(MAXS), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr),
    .i_prog_data(i_prog_data), .i_num_steps(i_num_steps), .i_start(i_start),
    .i_abort(i_abort), .i_board(i_board), .o_eng_start(o_eng_start),
    .o_eng_board(o_eng_board), .o_eng_mask(o_eng_mask), .o_eng_number(o_eng_number),
    .o_eng_target(o_eng_target), .o_eng_flag(o_eng_flag), .i_eng_done(i_eng_done),
    .i_eng_fail(i_eng_fail), .i_eng_board(i_eng_board), .i_eng_mask(i_eng_mask),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code),
    .o_step(o_step), .o_board(o_board)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine behaviour: swap the tile `number` into `target`, lock target; flag unlocks all.
  function automatic logic [BW+N-1:0] move(input logic [BW-1:0] b, input logic [N-1:0] m,
                                           input logic [EW-1:0] e);
    int cells[N];
    int p, t, tmp;
    logic [BW-1:0] nb;
    logic [N-1:0] nm;
    for (int i = 0; i < N; i++) cells[i] = int'(b[i*CELL_W +: CELL_W]);
    t = int'(e[IDXW-1:0]);
    p = -1;
    for (int i = 0; i < N; i++) if (p < 0 && cells[i] == int'(e[IDXW +: CELL_W])) p = i;
    if (p < 0) p = t;
    tmp = cells[p];
    cells[p] = cells[t];
    cells[t] = tmp;
    for (int i = 0; i < N; i++) nb[i*CELL_W +: CELL_W] = CELL_W'(cells[i]);
    nm = e[EW-1] ? '0 : (m | (N'(1) << t));
    return {nb, nm};
  endfunction

  typedef struct {
    int            kind;  // 0 launch, 1 done, 2 error
    int            cyc;
    int            step;
    logic [EW-1:0] ent;
    logic [BW-1:0] board;
    logic [N-1:0]  mask;
    int            code;
  } exp_t;

  exp_t sb[$];
  logic [EW-1:0] tbl[MAXS];
  logic [BW-1:0] exp_board;

  function automatic exp_t mk(input int kind, input int c, input int step, input logic [EW-1:0] ent,
                              input logic [BW-1:0] board, input logic [N-1:0] mask, input int code);
    exp_t e;
    e.kind = kind; e.cyc = c; e.step = step; e.ent = ent;
    e.board = board; e.mask = mask; e.code = code;
    return e;
  endfunction

  function automatic logic [127:0] exp_vec(input exp_t e);
    logic [2:0] kb;
    kb = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
    if (e.kind == 0) return {kb, 32'(e.cyc), SW'(e.step), e.ent, e.board, e.mask};
    return {kb, 32'(e.cyc), SW'(e.step), 9'd0, e.board, {1'b0, 2'(e.code), 13'd0}};
  endfunction

  // Monitor: every launch/done/error pops the oldest expectation.
  logic [127:0] mon_act;
  exp_t mon_e;
  always @(negedge clk) begin
    if (i_rst_n && (o_eng_start || o_done || o_error)) begin
      mon_act = {o_eng_start, o_done, o_error, 32'(cyc), o_step,
                 o_eng_start ? {o_eng_flag, o_eng_number, o_eng_target} : 9'd0,
                 o_eng_start ? o_eng_board : o_board,
                 o_eng_start ? o_eng_mask : {o_busy, o_err_code, 13'd0}};
      if (sb.size() == 0) begin
        check("unexpected_event", mon_act, '0);
      end else begin
        mon_e = sb.pop_front();
        check((mon_e.kind == 0) ? "launch" : (mon_e.kind == 1) ? "done" : "error",
              mon_act, exp_vec(mon_e));
      end
    end
  end

  // Engine model configuration, written only by the stimulus process.
  int eng_lat = 1;
  int eng_fail = -1;
  int eng_abort = -1;
  bit eng_silent = 1'b0;
  int eng_cnt = 0;
  int eng_idx = 0;
  logic [BW-1:0] snap_b;
  logic [N-1:0]  snap_m;
  logic [EW-1:0] snap_e;
  logic [BW+N-1:0] eng_r;

  always @(negedge clk) begin
    i_eng_done = 1'b0;
    i_eng_fail = 1'b0;
    i_abort    = 1'b0;
    if (!i_rst_n) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0 && !eng_silent) begin
          i_eng_done = 1'b1;
          if (eng_idx == eng_fail) begin
            i_eng_fail  = 1'b1;
            i_eng_board = {$urandom, $urandom};
            i_eng_mask  = N'($urandom);
          end else begin
            eng_r = move(snap_b, snap_m, snap_e);
            i_eng_board = eng_r[BW+N-1:N];
            i_eng_mask  = eng_r[N-1:0];
          end
          if (eng_idx == eng_abort) i_abort = 1'b1;
        end
      end
      if (o_eng_start) begin
        snap_b  = o_eng_board;
        snap_m  = o_eng_mask;
        snap_e  = {o_eng_flag, o_eng_number, o_eng_target};
        eng_idx = int'(o_step);
        eng_cnt = eng_lat;
      end
    end
  end

  task automatic prog_all();
    for (int a = 0; a < MAXS; a++) begin
      @(negedge clk);
      i_prog_we = 1'b1;
      i_prog_addr = AW'(a);
      i_prog_data = tbl[a];
    end
    @(negedge clk);
    i_prog_we = 1'b0;
  endtask

  task automatic start_run(input int n, input int lat, input int fail, input bit silent,
                           input int abrt, input bit disturb);
    int nn, k;
    logic [BW-1:0] b;
    logic [N-1:0] m;
    logic [BW+N-1:0] r;
    @(negedge clk);
    for (int i = 0; i < N; i++) b[i*CELL_W +: CELL_W] = CELL_W'($urandom_range(0, 15));
    eng_lat = lat; eng_fail = fail; eng_silent = silent; eng_abort = abrt;
    i_board = b;
    i_num_steps = SW'(n);
    i_start = 1'b1;
    k = cyc + 1;
    nn = (n > MAXS) ? MAXS : n;
    m = '0;
    if (nn == 0) sb.push_back(mk(1, k, 0, '0, b, '0, 0));
    for (int i = 0; i < nn; i++) begin
      sb.push_back(mk(0, k + i * (lat + 1), i, tbl[i], b, m, 0));
      if (i == abrt) break;
      if (silent) begin
        sb.push_back(mk(2, k + i * (lat + 1) + TO + 1, i, '0, b, '0, 2));
        break;
      end
      if (i == fail) begin
        sb.push_back(mk(2, k + (i + 1) * (lat + 1), i, '0, b, '0, 1));
        break;
      end
      r = move(b, m, tbl[i]);
      b = r[BW+N-1:N];
      m = r[N-1:0];
      if (i == nn - 1) sb.push_back(mk(1, k + nn * (lat + 1), nn, '0, b, '0, 0));
    end
    exp_board = b;
    @(negedge clk);
    i_start = 1'b0;
    if (disturb && nn > 0) begin
      // Sequencer is in its launch cycle here: both requests must be ignored.
      i_prog_we = 1'b1;
      i_prog_addr = AW'(1);
      i_prog_data = ~tbl[1];
      i_start = 1'b1;
      i_num_steps = '0;
      @(negedge clk);
      i_prog_we = 1'b0;
      i_start = 1'b0;
    end
  endtask

  task automatic finish_run();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    check("run_end", 128'({(sb.size() == 0), o_busy, o_board}), 128'({1'b1, 1'b0, exp_board}));
    if (!ok) sb.delete();
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 128'({o_eng_start, o_eng_mask, o_eng_number, o_eng_target, o_eng_flag,
                              o_busy, o_done, o_error, o_err_code, o_step}), '0);
    check("reset_board", 128'({o_eng_board, o_board}), '0);
    i_rst_n = 1'b1;

    for (int a = 0; a < MAXS; a++) tbl[a] = EW'($urandom);
    tbl[0] = {1'b0, 4'd1, 4'd0};
    tbl[1] = {1'b0, 4'd2, 4'd1};
    tbl[2] = {1'b1, 4'd3, 4'd2};
    prog_all();

    start_run(3, 5, -1, 1'b0, -1, 1'b0);   // three-step chain
    finish_run();
    start_run(0, 3, -1, 1'b0, -1, 1'b0);   // zero steps: immediate done
    finish_run();
    start_run(3, 4, 1, 1'b0, -1, 1'b0);    // engine fail on step 1
    finish_run();
    check("err_held", 128'({o_err_code, o_step}), 128'({2'd1, 4'd1}));
    start_run(2, 3, -1, 1'b1, -1, 1'b0);   // engine silent: watchdog
    finish_run();
    check("timeout_code", 128'({o_err_code, o_step}), 128'({2'd2, 4'd0}));
    start_run(3, 4, -1, 1'b0, 1, 1'b0);    // abort together with done
    finish_run();
    check("abort_quiet", 128'({o_err_code, o_step}), 128'({2'd0, 4'd1}));
    start_run(3, 2, -1, 1'b0, -1, 1'b0);   // restart from step 0
    finish_run();
    start_run(3, 3, -1, 1'b0, -1, 1'b1);   // writes/start while busy
    finish_run();
    start_run(12, 1, -1, 1'b0, -1, 1'b0);  // clamped to table depth
    finish_run();

    // Asynchronous reset in the middle of a wait.
    start_run(3, 6, -1, 1'b0, -1, 1'b0);
    repeat (3) @(negedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", 128'({o_eng_start, o_eng_mask, o_eng_number, o_eng_target,
                                  o_eng_flag, o_busy, o_done, o_error, o_err_code, o_step}), '0);
    check("async_rst_board", 128'({o_eng_board, o_board}), '0);
    sb.delete();
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    prog_all();
    start_run(3, 2, -1, 1'b0, -1, 1'b0);
    finish_run();

    for (int it = 0; it < 10; it++) begin
      for (int a = 0; a < MAXS; a++) tbl[a] = EW'($urandom);
      prog_all();
      start_run(int'($urandom_range(0, 11)), int'($urandom_range(1, 6)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                1'b0,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1,
                1'($urandom_range(0, 1)));
      finish_run();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
